// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front-end blocks.
package fft_pkg;

    localparam int RE        = 0;
    localparam int IM        = 1;
    localparam int DEF_WIDTH = 12;

    // One complex sample: [RE] real part, [IM] imaginary part.
    typedef logic signed [1:0][DEF_WIDTH-1:0] cplx_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_sample_counter.sv
// Mod-N sample index counter with increment, synchronous clear and terminal flag.
module fft_sample_counter
    import fft_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [IW-1:0] k,
    output logic          last
);

    assign last = (k == IW'(N - 1));

    // Clear wins over increment so an aborted frame always restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (clr) begin
            k <= '0;
        end else if (inc) begin
            k <= last ? '0 : k + IW'(1);
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// Collects N complex samples into even/odd arrays for the radix-2 butterfly
// and holds the frame until the consumer takes it.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 12
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [WIDTH-1:0]               in_re,
    input  logic signed [WIDTH-1:0]               in_im,
    input  logic                                  in_last,
    output logic signed [N/2-1:0][1:0][WIDTH-1:0] evens,
    output logic signed [N/2-1:0][1:0][WIDTH-1:0] odds,
    output logic                                  frame_valid,
    input  logic                                  frame_ready,
    output logic                                  frame_err,
    output logic [15:0]                           frame_cnt
);

    localparam int IW = idx_width(N);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready depends only on registered state, never on the valid of the same side.
    state_e        state;
    state_e        state_nxt;
    logic [IW-1:0] k;
    logic          k_last;
    logic          accept;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          early_last;
    logic          drain;

    fft_sample_counter #(.N(N)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .k     (k),
        .last  (k_last)
    );

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        early_last  = 1'b0;
        drain       = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_inc = 1'b1;
                    if (k_last) begin
                        state_nxt = FULL;
                    end else if (in_last) begin
                        early_last = 1'b1;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            FULL: begin
                frame_valid = 1'b1;
                if (frame_ready) begin
                    drain     = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            frame_err <= early_last;
            if (drain) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Sample k lands in evens[k/2] for even k, odds[k/2] for odd k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evens <= '0;
            odds  <= '0;
        end else if (accept) begin
            for (int i = 0; i < N / 2; i++) begin
                if (k == IW'(2 * i)) begin
                    evens[i][RE] <= in_re;
                    evens[i][IM] <= in_im;
                end
                if (k == IW'(2 * i + 1)) begin
                    odds[i][RE] <= in_re;
                    odds[i][IM] <= in_im;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader with a frame scoreboard.
module tb_fft_sample_loader;
    import fft_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 12;
    localparam int FW    = N * 2 * WIDTH;

    logic                                  clk = 1'b0;
    logic                                  rst_n = 1'b0;
    logic                                  in_valid = 1'b0;
    logic                                  in_last = 1'b0;
    logic                                  frame_ready = 1'b0;
    logic signed [WIDTH-1:0]               in_re = '0;
    logic signed [WIDTH-1:0]               in_im = '0;
    logic                                  in_ready;
    logic                                  frame_valid;
    logic                                  frame_err;
    logic [15:0]                           frame_cnt;
    logic signed [N/2-1:0][1:0][WIDTH-1:0] evens;
    logic signed [N/2-1:0][1:0][WIDTH-1:0] odds;

    logic signed [N/2-1:0][1:0][WIDTH-1:0] m_evens;
    logic signed [N/2-1:0][1:0][WIDTH-1:0] m_odds;
    logic signed [N/2-1:0][1:0][WIDTH-1:0] ev_exp;
    logic signed [N/2-1:0][1:0][WIDTH-1:0] od_exp;
    logic [FW-1:0] exp_q[$];
    int mk = 0;
    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int c0;
    int c1;

    fft_sample_loader #(.N(N), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_last     (in_last),
        .evens       (evens),
        .odds        (odds),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_evens = '0;
        m_odds  = '0;
        mk      = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im,
                        input logic last);
        int  waited = 0;
        bit  ok = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        while (!ok && waited <= 20) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            check("send_timeout", FW'(in_ready), FW'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (mk % 2 == 0) begin
            m_evens[mk/2][RE] = re;
            m_evens[mk/2][IM] = im;
        end else begin
            m_odds[mk/2][RE] = re;
            m_odds[mk/2][IM] = im;
        end
        if (mk == N - 1) begin
            exp_q.push_back({m_odds, m_evens});
            mk = 0;
        end else if (last) begin
            mk = 0;
        end else begin
            mk++;
        end
    endtask

    task automatic drain_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_wait", FW'(frame_valid), FW'(1));
        @(posedge clk); #1 frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
    endtask

    // Scoreboard: every frame_valid must be backed by an expected frame.
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL spurious_frame observed=%0h expected=none", {odds, evens});
            end
            if (frame_ready && exp_q.size() > 0) check("frame_data", {odds, evens}, exp_q.pop_front());
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", FW'(in_ready), FW'(1));
        check("rst_frame_valid", FW'(frame_valid), FW'(0));
        check("rst_frame_err", FW'(frame_err), FW'(0));
        check("rst_frame_cnt", FW'(frame_cnt), FW'(0));
        check("rst_arrays", {odds, evens}, '0);

        // Basic frame, held without consumer
        @(posedge clk); #1;
        send(12'sd1, 12'sd0, 1'b0);
        send(12'sd2, -12'sd1, 1'b0);
        send(12'sd3, 12'sd5, 1'b0);
        send(-12'sd4, 12'sd7, 1'b1);
        ev_exp[0][RE] = 12'sd1;  ev_exp[0][IM] = 12'sd0;
        ev_exp[1][RE] = 12'sd3;  ev_exp[1][IM] = 12'sd5;
        od_exp[0][RE] = 12'sd2;  od_exp[0][IM] = -12'sd1;
        od_exp[1][RE] = -12'sd4; od_exp[1][IM] = 12'sd7;
        @(negedge clk);
        check("full_frame_valid", FW'(frame_valid), FW'(1));
        check("full_in_ready", FW'(in_ready), FW'(0));
        check("full_evens", FW'(evens), FW'(ev_exp));
        check("full_odds", FW'(odds), FW'(od_exp));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_re    = WIDTH'($urandom_range(4095));
            in_im    = WIDTH'($urandom_range(4095));
            @(negedge clk);
            check("hold_frame", {odds, evens}, {od_exp, ev_exp});
            check("hold_valid", FW'(frame_valid), FW'(1));
        end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
        @(negedge clk);
        check("drain_frame_valid", FW'(frame_valid), FW'(0));
        check("drain_frame_cnt", FW'(frame_cnt), FW'(1));
        check("drain_in_ready", FW'(in_ready), FW'(1));

        // Extreme values stored bit-exact
        @(posedge clk); #1;
        send(-12'sd2048, 12'sd2047, 1'b0);
        send(12'sd2047, -12'sd2048, 1'b0);
        send(-12'sd2048, -12'sd2048, 1'b0);
        send(12'sd2047, 12'sd2047, 1'b1);
        drain_frame();
        @(negedge clk);
        check("extreme_frame_cnt", FW'(frame_cnt), FW'(2));

        // Early last aborts the partial frame
        @(posedge clk); #1;
        send(12'sd11, -12'sd11, 1'b0);
        send(12'sd12, -12'sd12, 1'b1);
        @(negedge clk);
        check("early_err_pulse", FW'(frame_err), FW'(1));
        check("early_no_valid", FW'(frame_valid), FW'(0));
        @(negedge clk);
        check("early_err_clear", FW'(frame_err), FW'(0));
        check("early_no_valid2", FW'(frame_valid), FW'(0));
        @(posedge clk); #1;
        send(12'sd21, 12'sd121, 1'b0);
        send(-12'sd22, 12'sd122, 1'b0);
        send(12'sd23, -12'sd123, 1'b0);
        send(-12'sd24, -12'sd124, 1'b1);
        drain_frame();
        @(negedge clk);
        check("after_early_cnt", FW'(frame_cnt), FW'(3));

        // Asynchronous reset mid-frame
        @(posedge clk); #1;
        send(12'sd31, -12'sd31, 1'b0);
        send(12'sd32, -12'sd32, 1'b0);
        send(12'sd33, -12'sd33, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_in_ready", FW'(in_ready), FW'(1));
        check("async_frame_valid", FW'(frame_valid), FW'(0));
        check("async_frame_cnt", FW'(frame_cnt), FW'(0));
        check("async_frame_err", FW'(frame_err), FW'(0));
        check("async_arrays", {odds, evens}, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(12'sd41, 12'sd141, 1'b0);
        send(12'sd42, 12'sd142, 1'b0);
        send(12'sd43, 12'sd143, 1'b0);
        send(12'sd44, 12'sd144, 1'b1);
        drain_frame();
        @(negedge clk);
        check("post_reset_cnt", FW'(frame_cnt), FW'(1));

        // Back-to-back frames with consumer always ready
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b1;
        c0 = cycle;
        for (int f = 0; f < 20; f++) begin
            for (int s = 0; s < N; s++) begin
                send(WIDTH'($urandom_range(4095)), WIDTH'($urandom_range(4095)), s == N - 1);
            end
        end
        c1 = cycle;
        check("b2b_cycles", FW'(c1 - c0), FW'(20 * (N + 1) - 1));
        @(negedge clk);
        @(posedge clk); #1 frame_ready = 1'b0;
        @(negedge clk);
        check("b2b_frame_cnt", FW'(frame_cnt), FW'(20));
        check("b2b_queue_empty", FW'(exp_q.size()), FW'(0));
        check("b2b_frame_valid", FW'(frame_valid), FW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
